// File: rtl/serial_comparator_pkg.sv
// Shared types and defaults for the bit-serial magnitude comparator.
// The state encoding lives here so the FSM and any observers agree on it.
package serial_comparator_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } cmp_state_t;

   localparam int CMP_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in / serial-out shift register presenting its MSB each cycle.
// Load takes priority over shift; shifts are zero-filled.
module piso_shift_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] d,
   output logic             msb
);

   logic [WIDTH-1:0] sr_q;
   logic [WIDTH-1:0] sr_d;

   always_comb begin
      sr_d = sr_q;
      if (load) begin
         sr_d = d;
      end else if (shift) begin
         sr_d = {sr_q[WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign msb = sr_q[WIDTH-1];

endmodule

// File: rtl/serial_comparator_8bit.sv
// Bit-serial MSB-first unsigned magnitude comparator with start/ready/done handshake.
// One bit pair is examined per clock; the first differing bit decides g/l.
module serial_comparator_8bit
   import serial_comparator_pkg::*;
#(
   parameter int WIDTH      = CMP_WIDTH_DEFAULT,
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             ready,
   output logic             done,
   output logic             g,
   output logic             l,
   output logic             eq
);

   localparam int CNT_W = $clog2(WIDTH);

   cmp_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             g_q, g_d;
   logic             l_q, l_d;
   logic             eq_q, eq_d;
   logic             a_msb, b_msb;
   logic             load, shift;
   logic             bit_diff;
   logic             decided;

   piso_shift_reg #(.WIDTH(WIDTH)) u_a_sr (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .shift (shift),
      .d     (A),
      .msb   (a_msb)
   );

   piso_shift_reg #(.WIDTH(WIDTH)) u_b_sr (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .shift (shift),
      .d     (B),
      .msb   (b_msb)
   );

   assign bit_diff = a_msb ^ b_msb;
   assign decided  = g_q | l_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = SHIFT;
         SHIFT: begin
            if (EARLY_EXIT && bit_diff) begin
               state_d = DONE;
            end else if (cnt_q == '0) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ready = (state_q == IDLE);
      done  = (state_q == DONE);
      load  = ready & start;
      shift = (state_q == SHIFT);
   end

   // Only the first differing bit may set g/l; later bits are ignored in full-scan mode.
   always_comb begin
      cnt_d = cnt_q;
      g_d   = g_q;
      l_d   = l_q;
      eq_d  = eq_q;
      if (load) begin
         cnt_d = CNT_W'(WIDTH - 1);
         g_d   = 1'b0;
         l_d   = 1'b0;
         eq_d  = 1'b0;
      end else if (shift) begin
         cnt_d = cnt_q - CNT_W'(1);
         if (!decided) begin
            g_d = a_msb & ~b_msb;
            l_d = ~a_msb & b_msb;
         end
         if ((cnt_q == '0) && !decided && !bit_diff) begin
            eq_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         g_q   <= 1'b0;
         l_q   <= 1'b0;
         eq_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         g_q   <= g_d;
         l_q   <= l_d;
         eq_q  <= eq_d;
      end
   end

   assign g  = g_q;
   assign l  = l_q;
   assign eq = eq_q;

endmodule

// File: tb/tb_serial_comparator_8bit.sv
// Directed and random checks of the serial comparator in early-exit (inst 0)
// and full-scan (inst 1) configurations, using a result/latency scoreboard.
module tb_serial_comparator_8bit;

   logic       clk = 1'b0;
   logic       rst;
   logic       start0, start1;
   logic [7:0] a0, b0, a1, b1;
   logic       ready0, done0, g0, l0, eq0;
   logic       ready1, done1, g1, l1, eq1;

   typedef struct {
      logic g;
      logic l;
      logic eq;
      int   lat;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;
   int   lat_cnt  = 0;

   always #5 clk = ~clk;

   serial_comparator_8bit #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut_ee (
      .clk   (clk),
      .rst   (rst),
      .start (start0),
      .A     (a0),
      .B     (b0),
      .ready (ready0),
      .done  (done0),
      .g     (g0),
      .l     (l0),
      .eq    (eq0)
   );

   serial_comparator_8bit #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut_fs (
      .clk   (clk),
      .rst   (rst),
      .start (start1),
      .A     (a1),
      .B     (b1),
      .ready (ready1),
      .done  (done1),
      .g     (g1),
      .l     (l1),
      .eq    (eq1)
   );

   // {ready, done, g, l, eq}
   function automatic logic [4:0] outs(input int w);
      return (w == 0) ? {ready0, done0, g0, l0, eq0} : {ready1, done1, g1, l1, eq1};
   endfunction

   function automatic int exp_lat(input int w, input logic [7:0] a, input logic [7:0] b);
      logic [7:0] x;
      x = a ^ b;
      if (w == 1 || x == 8'd0) return 9;
      for (int k = 7; k >= 0; k--) begin
         if (x[k]) return (8 - k) + 1;
      end
      return 9;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_start(input int w, input logic s);
      if (w == 0) start0 = s; else start1 = s;
   endtask

   task automatic set_ab(input int w, input logic [7:0] a, input logic [7:0] b);
      if (w == 0) begin a0 = a; b0 = b; end
      else begin a1 = a; b1 = b; end
   endtask

   // Called at a negedge while the DUT is idle; returns at the negedge after the accepting edge.
   task automatic accept(input int w, input logic [7:0] a, input logic [7:0] b, input bit hold);
      exp_t       e;
      logic [4:0] o;
      o = outs(w);
      check("ready_before_accept", o[4], 1);
      set_start(w, 1'b1);
      set_ab(w, a, b);
      e.g   = (a > b);
      e.l   = (a < b);
      e.eq  = (a == b);
      e.lat = exp_lat(w, a, b);
      sb.push_back(e);
      $display("inst%0d accept A=%0d B=%0d exp g=%0d l=%0d eq=%0d lat=%0d",
               w, a, b, e.g, e.l, e.eq, e.lat);
      @(posedge clk);
      lat_cnt = 1;
      @(negedge clk);
      if (!hold) set_start(w, 1'b0);
   endtask

   task automatic wait_done(input int w, input bit scramble);
      logic [4:0] o;
      exp_t       e;
      o = outs(w);
      while (!o[3] && lat_cnt < 40) begin
         @(posedge clk);
         lat_cnt++;
         @(negedge clk);
         o = outs(w);
         if (scramble && !o[3]) set_ab(w, 8'($urandom), 8'($urandom));
      end
      check("done_seen", o[3], 1);
      if (sb.size() == 0) begin
         check("scoreboard_nonempty", 0, 1);
         return;
      end
      e = sb.pop_front();
      check("g", o[2], e.g);
      check("l", o[1], e.l);
      check("eq", o[0], e.eq);
      check("latency", lat_cnt, e.lat);
      check("onehot", $countones(o[2:0]), 1);
      check("ready_at_done", o[4], 0);
      $display("inst%0d done g=%0d l=%0d eq=%0d lat=%0d", w, o[2], o[1], o[0], lat_cnt);
      @(posedge clk);
      @(negedge clk);
      o = outs(w);
      check("done_one_cycle", o[3], 0);
      check("ready_after_done", o[4], 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0] o;
      logic [7:0] ra, rb;

      rst = 1'b1;
      start0 = 1'b0; start1 = 1'b0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      @(negedge clk);
      o = outs(0);
      check("reset_outs0", o, 5'b10000);
      o = outs(1);
      check("reset_outs1", o, 5'b10000);
      rst = 1'b0;
      @(negedge clk);

      accept(0, 8'd255, 8'd0, 1'b0);   wait_done(0, 1'b0);
      accept(0, 8'd144, 8'd88, 1'b0);  wait_done(0, 1'b0);
      accept(0, 8'd88, 8'd88, 1'b0);   wait_done(0, 1'b0);
      accept(0, 8'd0, 8'd1, 1'b0);     wait_done(0, 1'b0);
      accept(1, 8'd255, 8'd0, 1'b0);   wait_done(1, 1'b0);
      accept(1, 8'd0, 8'd1, 1'b0);     wait_done(1, 1'b0);
      accept(1, 8'd77, 8'd77, 1'b0);   wait_done(1, 1'b0);

      // start pulsed mid-compare with new operands must be ignored
      accept(0, 8'd16, 8'd8, 1'b0);
      set_start(0, 1'b1);
      set_ab(0, 8'd1, 8'd200);
      @(posedge clk);
      lat_cnt++;
      @(negedge clk);
      set_start(0, 1'b0);
      wait_done(0, 1'b0);
      for (int i = 0; i < 12; i++) begin
         o = outs(0);
         check("no_second_done", o[3], 0);
         check("result_held", o[2:0], 3'b100);
         @(negedge clk);
      end

      // asynchronous reset mid-compare
      accept(0, 8'd3, 8'd2, 1'b0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      o = outs(0);
      check("async_reset_outs", o, 5'b10000);
      void'(sb.pop_front());
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         o = outs(0);
         check("no_done_after_abort", o[3], 0);
      end
      accept(0, 8'd2, 8'd3, 1'b0);     wait_done(0, 1'b0);

      // random regression, start held high, operands scrambled during SHIFT
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? ra : 8'($urandom);
         accept(0, ra, rb, 1'b1);
         wait_done(0, 1'b1);
      end
      set_start(0, 1'b0);
      for (int i = 0; i < 200; i++) begin
         ra = 8'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? ra : 8'($urandom);
         accept(1, ra, rb, 1'b1);
         wait_done(1, 1'b1);
      end
      set_start(1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
